// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 device emulator.
// Provides the {be,data} bus word type, byte-enable codes and a FIFO
// occupancy helper used to register the bus flags from next-state counts.
package ft600_pkg;

  localparam int unsigned FT600_DATA_W = 16;
  localparam int unsigned FT600_BE_W   = 2;

  typedef struct packed {
    logic [FT600_BE_W-1:0]   be;
    logic [FT600_DATA_W-1:0] data;
  } ft600_word_t;

  localparam logic [FT600_BE_W-1:0] BE_BOTH = 2'b11;
  localparam logic [FT600_BE_W-1:0] BE_LOW  = 2'b01;
  localparam logic [FT600_BE_W-1:0] BE_HIGH = 2'b10;

  // Occupancy after one edge given the qualified push/pop of that edge.
  function automatic int unsigned next_count(int unsigned count, logic push, logic pop);
    int unsigned n;
    n = count;
    if (push) n = n + 32'd1;
    if (pop)  n = n - 32'd1;
    return n;
  endfunction

endpackage

// File: rtl/ft600_device_emulator_if.sv
// Bus bundle between the FPGA-side FT600 master / host model and the emulator.
// slave  : the emulator (chip side) - drives flags, read data, host handshakes.
// master : the FPGA master plus host model - drives strobes, write data, host data.
interface ft600_device_emulator_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  import ft600_pkg::*;

  logic                    ftdi_rxf_n;
  logic                    ftdi_txe_n;
  logic                    ftdi_oe_n;
  logic                    ftdi_rd_n;
  logic                    ftdi_wr_n;
  logic [FT600_DATA_W-1:0] ftdi_data_i;
  logic [FT600_BE_W-1:0]   ftdi_be_i;
  logic [FT600_DATA_W-1:0] ftdi_data_o;
  logic [FT600_BE_W-1:0]   ftdi_be_o;
  logic                    ftdi_bus_oe;
  logic                    host_tx_valid;
  logic                    host_tx_ready;
  logic [FT600_DATA_W-1:0] host_tx_data;
  logic [FT600_BE_W-1:0]   host_tx_be;
  logic                    host_rx_valid;
  logic                    host_rx_ready;
  logic [FT600_DATA_W-1:0] host_rx_data;
  logic [FT600_BE_W-1:0]   host_rx_be;
  logic [DEPTH_LOG2:0]     rx_count;
  logic [DEPTH_LOG2:0]     tx_count;
  logic                    protocol_err;

  modport slave (
    input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i,
    input  host_tx_valid, host_tx_data, host_tx_be, host_rx_ready,
    output ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_bus_oe,
    output host_tx_ready, host_rx_valid, host_rx_data, host_rx_be,
    output rx_count, tx_count, protocol_err
  );

  modport master (
    output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_i, ftdi_be_i,
    output host_tx_valid, host_tx_data, host_tx_be, host_rx_ready,
    input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_o, ftdi_be_o, ftdi_bus_oe,
    input  host_tx_ready, host_rx_valid, host_rx_data, host_rx_be,
    input  rx_count, tx_count, protocol_err
  );

endinterface

// File: rtl/ft600_emu_fifo.sv
// Synchronous show-ahead FIFO of ft600_word_t, 2**DEPTH_LOG2 entries.
// clk_i/rst_ni : clock, async active-low reset (pointers and count only)
// push_i/wdata_i : write, ignored when full
// pop_i/rdata_o  : read, rdata_o is the head word, 0 when empty
// full_o/empty_o/count_o : status, count_o is DEPTH_LOG2+1 bits
module ft600_emu_fifo
  import ft600_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  ft600_word_t         wdata_i,
  input  logic                pop_i,
  output ft600_word_t         rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  ft600_word_t           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ft600_device_emulator.sv
// Chip-side model of the FT600 245-style synchronous FIFO bus.
// ftdi_clk/rst_n : bus clock, async active-low reset
// bus (slave)    : FT600 pins toward the FPGA master, host push/pop handshakes,
//                  FIFO occupancies and a sticky protocol_err flag.
// RX FIFO carries host->FPGA words, TX FIFO carries FPGA->host words.
module ft600_device_emulator
  import ft600_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = FT600_DATA_W,
  parameter int unsigned BE_W       = FT600_BE_W
) (
  input logic                    ftdi_clk,
  input logic                    rst_n,
  ft600_device_emulator_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   wr_data;
  logic [BE_W-1:0]     wr_be;
  ft600_word_t         rx_wdata, tx_wdata, rx_head, tx_head;
  logic                rx_push, rx_pop, tx_push, tx_pop;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic                rxf_n_q, txe_n_q, protocol_err_q;
  logic                rxf_n_d, txe_n_d, err_set;

  assign wr_data  = bus.ftdi_data_i;
  assign wr_be    = bus.ftdi_be_i;
  assign rx_wdata = '{be: bus.host_tx_be, data: bus.host_tx_data};
  assign tx_wdata = '{be: wr_be, data: wr_data};

  // Strobe qualification. A write during OE (contention) or while full never pushes,
  // and an all-zero byte enable carries no payload.
  assign rx_push = bus.host_tx_valid & bus.host_tx_ready;
  assign rx_pop  = ~bus.ftdi_oe_n & ~bus.ftdi_rd_n & ~rx_empty;
  assign tx_push = ~bus.ftdi_wr_n & bus.ftdi_oe_n & ~tx_full & (wr_be != '0);
  assign tx_pop  = bus.host_rx_valid & bus.host_rx_ready;
  assign err_set = ~bus.ftdi_wr_n & (~bus.ftdi_oe_n | tx_full);

  ft600_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (ftdi_clk),
    .rst_ni  (rst_n),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  ft600_emu_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (ftdi_clk),
    .rst_ni  (rst_n),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // Flags come from next-state occupancy so they move on the consuming edge.
  assign rxf_n_d = (next_count(32'(rx_count), rx_push, rx_pop) == 0);
  assign txe_n_d = (next_count(32'(tx_count), tx_push, tx_pop) == Depth);

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxf_n_q        <= 1'b1;
      txe_n_q        <= 1'b1;
      protocol_err_q <= 1'b0;
    end else begin
      rxf_n_q <= rxf_n_d;
      txe_n_q <= txe_n_d;
      if (err_set) protocol_err_q <= 1'b1;
    end
  end

  // Gated with rst_n so the bus is released and pushes refused while in reset.
  assign bus.ftdi_bus_oe   = ~bus.ftdi_oe_n & rst_n;
  assign bus.host_tx_ready = ~rx_full & rst_n;

  assign bus.ftdi_rxf_n    = rxf_n_q;
  assign bus.ftdi_txe_n    = txe_n_q;
  assign bus.ftdi_data_o   = rx_head.data;
  assign bus.ftdi_be_o     = rx_head.be;
  assign bus.host_rx_valid = ~tx_empty;
  assign bus.host_rx_data  = tx_head.data;
  assign bus.host_rx_be    = tx_head.be;
  assign bus.rx_count      = rx_count;
  assign bus.tx_count      = tx_count;
  assign bus.protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_ft600_device_emulator.sv
// Self-checking bench for ft600_device_emulator: queue-based chip model checked
// on every negedge, plus literal expectations for the directed scenarios.
module tb_ft600_device_emulator;
  import ft600_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft600_device_emulator_if #(.DEPTH_LOG2(4)) bus ();

  ft600_device_emulator #(.DEPTH_LOG2(4), .DATA_W(16), .BE_W(2)) dut (
    .ftdi_clk (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;

  logic [17:0] rxq[$];
  logic [17:0] txq[$];
  logic        m_err, m_rxf_n, m_txe_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_err   = 1'b0;
    m_rxf_n = 1'b1;
    m_txe_n = 1'b1;
  endtask

  // One rising edge of the chip, from the rules: decide every transfer on the
  // pre-edge occupancy, then apply pops before pushes.
  task automatic model_edge();
    int rs, ts;
    bit rx_push, rx_pop, tx_push, tx_pop;
    if (!rst_n) return;
    rs = rxq.size();
    ts = txq.size();
    rx_push = bus.host_tx_valid && rs < 16;
    rx_pop  = !bus.ftdi_oe_n && !bus.ftdi_rd_n && rs != 0;
    tx_push = !bus.ftdi_wr_n && bus.ftdi_oe_n && ts < 16 && bus.ftdi_be_i != 2'b00;
    tx_pop  = ts != 0 && bus.host_rx_ready;
    if (!bus.ftdi_wr_n && (!bus.ftdi_oe_n || ts == 16)) m_err = 1'b1;
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) rxq.push_back({bus.host_tx_be, bus.host_tx_data});
    if (tx_pop) void'(txq.pop_front());
    if (tx_push) txq.push_back({bus.ftdi_be_i, bus.ftdi_data_i});
    m_rxf_n = (rxq.size() == 0);
    m_txe_n = (txq.size() == 16);
  endtask

  task automatic compare_all();
    logic [17:0] rh, th;
    rh = (rxq.size() != 0) ? rxq[0] : 18'h0;
    th = (txq.size() != 0) ? txq[0] : 18'h0;
    chk("rxf_n", bus.ftdi_rxf_n, m_rxf_n);
    chk("txe_n", bus.ftdi_txe_n, m_txe_n);
    chk("bus_oe", bus.ftdi_bus_oe, !bus.ftdi_oe_n && rst_n);
    chk("data_o", bus.ftdi_data_o, rh[15:0]);
    chk("be_o", bus.ftdi_be_o, rh[17:16]);
    chk("rx_count", bus.rx_count, rxq.size());
    chk("tx_count", bus.tx_count, txq.size());
    chk("host_tx_ready", bus.host_tx_ready, rst_n && rxq.size() < 16);
    chk("host_rx_valid", bus.host_rx_valid, txq.size() != 0);
    if (txq.size() != 0) begin
      chk("host_rx_data", bus.host_rx_data, th[15:0]);
      chk("host_rx_be", bus.host_rx_be, th[17:16]);
    end
    chk("protocol_err", bus.protocol_err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.ftdi_oe_n     = 1'b0;  // low during reset: bus_oe must still be 0
    bus.ftdi_rd_n     = 1'b1;
    bus.ftdi_wr_n     = 1'b1;
    bus.ftdi_data_i   = '0;
    bus.ftdi_be_i     = '0;
    bus.host_tx_valid = 1'b0;
    bus.host_tx_data  = '0;
    bus.host_tx_be    = '0;
    bus.host_rx_ready = 1'b0;
    model_reset();

    // 1. reset values, then first edge after release
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    chk("rst_bus_oe", bus.ftdi_bus_oe, 0);
    chk("rst_rxf_n", bus.ftdi_rxf_n, 1);
    chk("rst_txe_n", bus.ftdi_txe_n, 1);
    chk("rst_tx_ready", bus.host_tx_ready, 0);
    bus.ftdi_oe_n = 1'b1;
    rst_n = 1'b1;
    step();
    chk("first_txe_n", bus.ftdi_txe_n, 0);
    chk("first_rxf_n", bus.ftdi_rxf_n, 1);

    // 2. host pushes three words, master reads them back
    bus.host_tx_valid = 1'b1;
    bus.host_tx_data = 16'h1234; bus.host_tx_be = BE_BOTH; step();
    bus.host_tx_data = 16'hABCD; bus.host_tx_be = BE_LOW;  step();
    bus.host_tx_data = 16'h0F0F; bus.host_tx_be = BE_HIGH; step();
    bus.host_tx_valid = 1'b0;
    bus.ftdi_oe_n = 1'b0;
    #1 chk("oe_bus_oe", bus.ftdi_bus_oe, 1);
    step();
    chk("rd_word0", bus.ftdi_data_o, 16'h1234);
    chk("rd_be0", bus.ftdi_be_o, 2'b11);
    chk("rd_rxf_n0", bus.ftdi_rxf_n, 0);
    bus.ftdi_rd_n = 1'b0;
    step();
    chk("rd_word1", bus.ftdi_data_o, 16'hABCD);
    chk("rd_be1", bus.ftdi_be_o, 2'b01);
    step();
    chk("rd_word2", bus.ftdi_data_o, 16'h0F0F);
    chk("rd_be2", bus.ftdi_be_o, 2'b10);
    step();
    chk("rd_last_rxf_n", bus.ftdi_rxf_n, 1);
    chk("rd_last_count", bus.rx_count, 0);
    chk("rd_empty_data", bus.ftdi_data_o, 0);
    step();  // read strobe while empty is ignored
    chk("rd_empty_err", bus.protocol_err, 0);
    chk("rd_empty_count", bus.rx_count, 0);
    bus.ftdi_rd_n = 1'b1;
    bus.ftdi_oe_n = 1'b1;

    // 3. fill TX with host stalled, overrun, then drain
    bus.ftdi_wr_n = 1'b0;
    bus.ftdi_be_i = BE_BOTH;
    for (int i = 0; i < 16; i++) begin
      bus.ftdi_data_i = 16'(i);
      step();
    end
    chk("fill_txe_n", bus.ftdi_txe_n, 1);
    chk("fill_count", bus.tx_count, 16);
    chk("fill_err", bus.protocol_err, 0);
    bus.ftdi_data_i = 16'h0010;
    step();
    chk("overrun_err", bus.protocol_err, 1);
    chk("overrun_count", bus.tx_count, 16);
    bus.ftdi_wr_n = 1'b1;
    bus.host_rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", bus.host_rx_data, i);
      step();
    end
    chk("drain_valid", bus.host_rx_valid, 0);
    chk("drain_txe_n", bus.ftdi_txe_n, 0);
    bus.host_rx_ready = 1'b0;
    pulse_reset();

    // 4. write during OE: contention
    bus.ftdi_oe_n = 1'b0;
    bus.ftdi_wr_n = 1'b0;
    bus.ftdi_data_i = 16'h5555;
    bus.ftdi_be_i = BE_BOTH;
    #1 chk("cont_bus_oe", bus.ftdi_bus_oe, 1);
    step();
    chk("cont_err", bus.protocol_err, 1);
    chk("cont_count", bus.tx_count, 0);
    bus.ftdi_wr_n = 1'b1;
    bus.ftdi_oe_n = 1'b1;
    pulse_reset();

    // zero byte-enable write is discarded silently
    bus.ftdi_wr_n = 1'b0;
    bus.ftdi_be_i = 2'b00;
    bus.ftdi_data_i = 16'h7777;
    step();
    chk("be0_count", bus.tx_count, 0);
    chk("be0_err", bus.protocol_err, 0);
    bus.ftdi_wr_n = 1'b1;

    // 5. simultaneous push and pop on RX
    bus.host_tx_valid = 1'b1;
    bus.host_tx_data = 16'h0011; bus.host_tx_be = BE_BOTH;
    step();
    chk("sim_pre_count", bus.rx_count, 1);
    bus.host_tx_data = 16'h00AA;
    bus.ftdi_oe_n = 1'b0;
    bus.ftdi_rd_n = 1'b0;
    step();
    bus.host_tx_valid = 1'b0;
    bus.ftdi_rd_n = 1'b1;
    chk("sim_count", bus.rx_count, 1);
    chk("sim_rxf_n", bus.ftdi_rxf_n, 0);
    chk("sim_data", bus.ftdi_data_o, 16'h00AA);
    bus.ftdi_oe_n = 1'b1;
    pulse_reset();

    // full RX: host push refused even with a pop on the same edge
    bus.host_tx_valid = 1'b1;
    bus.host_tx_be = BE_BOTH;
    for (int i = 0; i < 16; i++) begin
      bus.host_tx_data = 16'h0200 + 16'(i);
      step();
    end
    chk("full_ready", bus.host_tx_ready, 0);
    bus.host_tx_data = 16'h02FF;
    bus.ftdi_oe_n = 1'b0;
    bus.ftdi_rd_n = 1'b0;
    step();
    bus.host_tx_valid = 1'b0;
    bus.ftdi_rd_n = 1'b1;
    chk("full_pop_count", bus.rx_count, 15);
    chk("full_pop_head", bus.ftdi_data_o, 16'h0201);
    bus.ftdi_oe_n = 1'b1;
    pulse_reset();

    // 6. reset in the middle of a read burst
    bus.host_tx_valid = 1'b1;
    bus.host_tx_be = BE_BOTH;
    for (int i = 0; i < 5; i++) begin
      bus.host_tx_data = 16'h0100 + 16'(i);
      step();
    end
    bus.host_tx_valid = 1'b0;
    bus.ftdi_oe_n = 1'b0;
    bus.ftdi_rd_n = 1'b0;
    step();
    step();
    bus.ftdi_rd_n = 1'b1;
    chk("mid_count", bus.rx_count, 3);
    chk("mid_head", bus.ftdi_data_o, 16'h0102);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rxf_n", bus.ftdi_rxf_n, 1);
    chk("async_count", bus.rx_count, 0);
    chk("async_bus_oe", bus.ftdi_bus_oe, 0);
    compare_all();
    bus.ftdi_oe_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_count", bus.rx_count, 0);
    chk("post_rxf_n", bus.ftdi_rxf_n, 1);
    chk("post_data", bus.ftdi_data_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ft600_device_emulator.md
Name: ft600_device_emulator

Overview:
Synthesizable model of the FT600 chip side of the 245-style synchronous FIFO bus. It responds to the FPGA-side FT600 bus master exactly as the chip does. It holds an RX FIFO (host→FPGA words, read by the master via OE_N/RD_N) and a TX FIFO (FPGA→host words, written by the master via WR_N). Used for on-chip loopback, bring-up without a USB host, and as the bus responder in master-side benches.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 words of {be,data}).
DATA_W, 16, bus data width; fixed to the FT600 16-bit mode.
BE_W, 2, byte-enable width.

Ports:
ftdi_clk  in  1  bus clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
ftdi_rxf_n  out  1  low when the RX FIFO holds data.
ftdi_txe_n  out  1  low when the TX FIFO has space.
ftdi_oe_n  in  1  master output enable; low = emulator drives bus.
ftdi_rd_n  in  1  master read strobe.
ftdi_wr_n  in  1  master write strobe.
ftdi_data_i  in  DATA_W  bus data from the master.
ftdi_be_i  in  BE_W  byte enables from the master.
ftdi_data_o  out  DATA_W  bus data to the master (RX head word).
ftdi_be_o  out  BE_W  byte enables to the master.
ftdi_bus_oe  out  1  tri-state enable for data/be; the top level builds the inouts.
host_tx_valid / host_tx_ready  in/out  1  push handshake into the RX FIFO.
host_tx_data, host_tx_be  in  DATA_W, BE_W  word pushed toward the FPGA.
host_rx_valid / host_rx_ready  out/in  1  pop handshake from the TX FIFO.
host_rx_data, host_rx_be  out  DATA_W, BE_W  word written by the FPGA.
rx_count, tx_count  out  DEPTH_LOG2+1  FIFO occupancies.
protocol_err  out  1  sticky bus-violation flag.

Behaviour:
- One clock (ftdi_clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - ftdi_rxf_n=1, ftdi_txe_n=1, ftdi_bus_oe=0.
  - counts=0, protocol_err=0, FIFO pointers=0.
  - ftdi_data_o/ftdi_be_o=0, host_rx_valid=0, host_tx_ready=0.
- ftdi_bus_oe = ~ftdi_oe_n & rst_n. This is combinational, so bus turnaround follows OE_N within the same cycle.
- ftdi_data_o/ftdi_be_o: RX FIFO head word (show-ahead). Forced to 0 when the RX FIFO is empty.
- RX pop:
  - Occurs on a rising edge when oe_n=0, rd_n=0 and rx_count≠0.
  - The next word appears on the outputs after that edge, so there is 1 word per cycle with zero extra latency.
  - rd_n low while empty is ignored (no pop, no error), matching the chip.
- TX push:
  - Occurs on a rising edge when wr_n=0, oe_n=1 and tx_count<DEPTH; stores {be_i,data_i}.
  - A word with be_i=00 is discarded (no push).
- Flags, registered from next-state counts:
  - ftdi_rxf_n <= (rx_count_next==0).
  - ftdi_txe_n <= (tx_count_next==DEPTH).
  - The flag therefore deasserts on the same edge that consumes the last word or slot.
  - txe_n goes 0 on the first edge after reset release.
- Host side:
  - host_tx_ready = (rx_count<DEPTH), evaluated on the current count. A push when full is refused even if an FPGA pop occurs in the same cycle.
  - host_rx_valid = (tx_count≠0).
  - A pop occurs on host_rx_valid & host_rx_ready.
- Simultaneous push and pop on the same FIFO: count unchanged; both pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Counts are DEPTH_LOG2+1 bits and saturate at DEPTH by construction.
- protocol_err is set, and stays set until reset, on:
  - (a) wr_n=0 while oe_n=0 (bus contention); no push occurs.
  - (b) wr_n=0 while the TX FIFO is full (overrun); the word is dropped.
- Reset mid-transfer flushes both FIFOs; in-flight words are lost. Flags return to reset values immediately on asynchronous assertion.

Decomposition:
- Package ft600_pkg:
  - FT600_DATA_W=16, FT600_BE_W=2.
  - typedef ft600_word_t {be, data}.
  - BE_BOTH=2'b11, BE_LOW=2'b01, BE_HIGH=2'b10.
- Sub-module ft600_emu_fifo:
  - Synchronous show-ahead FIFO of ft600_word_t; parameter DEPTH_LOG2.
  - Ports: push/pop/full/empty/count.
  - Instantiated twice (RX, TX).
- The top level holds strobe qualification, flag registers and the error logic.

Test Plan:
1. Reset with rst_n=0 for 3 cycles → rxf_n=1, txe_n=1, bus_oe=0, counts 0. First edge after release → txe_n=0, rxf_n stays 1.
2. Host pushes 0x1234/11, 0xABCD/01, 0x0F0F/10, then the master sets oe_n=0 followed by rd_n=0 for 3 cycles → data_o sequence 0x1234, 0xABCD, 0x0F0F with matching be. rxf_n=1 on the edge of the 3rd pop; rx_count=0.
3. host_rx_ready=0 while the master writes 0x0000..0x000F with be=11 → txe_n=1 after the 16th write. A 17th write sets protocol_err=1 with tx_count=16. Then host_rx_ready=1 → host_rx_data 0x0000..0x000F in order.
4. wr_n=0 with oe_n=0 and data 0x5555 → protocol_err=1, tx_count unchanged, bus_oe=1.
5. rx_count=1; host push of 0x00AA and an FPGA pop on the same edge → rx_count stays 1, rxf_n stays 0, data_o=0x00AA next.
6. 5 words queued, rst_n asserted after 2 pops → rxf_n=1 asynchronously; after release rx_count=0 and the RX FIFO is empty.
